key_multi_toggle: RTL and testbench
===================================

Name: key_multi_toggle

Overview:
- Parametrised successor to the single-key debounce/toggle block: NUM_KEYS independent channels, each with its own synchroniser, debounce FSM, toggle register, press/release pulses and long-press detection.
- Sits between raw board buttons and the HR/SpO2 control logic (mode select, display page, start/stop).
- Per-channel toggle clear lets the control logic force a known state.

Parameters:
- NUM_KEYS, 4, number of independent key channels (1..16).
- ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed; 0 = reads 1 when pressed.
- DEBOUNCE_CYCLES, 1000000, stable cycles required to accept a level change (20 ms at 50 MHz); minimum 2.
- LONG_CYCLES, 50000000, cycles held (counted from Press_Pulse) before Long_Pulse (1 s at 50 MHz); must exceed DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 10000000, auto-repeat period after a long press (used only with KEY_AUTO_REPEAT_EN).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Rst  in  1  asynchronous reset, active-high. The codebase clock name is kept; polarity and synchronicity are fixed.
- Key_In  in  NUM_KEYS  raw asynchronous key inputs.
- Toggle_Clr  in  NUM_KEYS  synchronous per-channel clear of Toggle_Out.
- Key_State  out  NUM_KEYS  debounced level, 1 = pressed (polarity-normalised).
- Press_Pulse  out  NUM_KEYS  1-cycle pulse on accepted press.
- Release_Pulse  out  NUM_KEYS  1-cycle pulse on accepted release.
- Long_Pulse  out  NUM_KEYS  1-cycle pulse once per press when held for LONG_CYCLES.
- Repeat_Pulse  out  NUM_KEYS  auto-repeat pulses; constant 0 when the feature is compiled out.
- Toggle_Out  out  NUM_KEYS  toggles on each accepted press.

Behaviour:
- Reset: all outputs are 0. Each FSM enters UP and all counters clear. A key held through reset must pass a full debounce before it registers as pressed.
- Input path: Key_In passes through a 2-FF synchroniser, then is inverted when ACTIVE_LOW=1, giving the normalised signal k (1 = pressed).
- FSM states per channel: UP, PRESS_FILT, DOWN, REL_FILT.
- UP: when k=1, go to PRESS_FILT and set cnt=0.
- PRESS_FILT:
  - k=0 → return to UP; no pulse.
  - Otherwise cnt increments.
  - At cnt==DEBOUNCE_CYCLES-1 with k=1 → go to DOWN, assert Press_Pulse for 1 cycle, set Key_State=1, clear the hold counter.
- DOWN:
  - Hold counter increments, saturating at LONG_CYCLES.
  - At hold==LONG_CYCLES-1 → assert Long_Pulse for 1 cycle; it fires only once per press.
  - k=0 → go to REL_FILT with cnt=0.
- REL_FILT:
  - k=1 → return to DOWN. The hold counter is NOT cleared, so a bounce does not restart long-press timing.
  - At cnt==DEBOUNCE_CYCLES-1 with k=0 → go to UP, assert Release_Pulse for 1 cycle, set Key_State=0.
- Latency: DEBOUNCE_CYCLES+3 Clk edges from the first edge that samples the new raw level to the pulse, given no bounce (2 synchroniser stages, 1 for FSM entry, DEBOUNCE_CYCLES-1 counting, 1 for the registered pulse). Release latency is identical.
- Toggle_Out:
  - Flips in the cycle after Press_Pulse is registered, i.e. the same edge that registers the pulse updates the toggle.
  - Long and repeat pulses do not flip it.
  - Toggle_Clr=1 forces 0 on the next edge. When Toggle_Clr and a press coincide, clear wins and the result is 0.
- Channels are fully independent; simultaneous events on multiple channels are all honoured in the same cycle.
- Counter widths are $clog2 of the respective cycle count; no wrap is possible because counters saturate or are cleared on state exit.

Optional Feature:
- Macro name: KEY_AUTO_REPEAT_EN.
- Defined:
  - After Long_Pulse, while the FSM remains in DOWN or REL_FILT, Repeat_Pulse fires every REPEAT_CYCLES cycles. The first repeat comes REPEAT_CYCLES after Long_Pulse.
  - The repeat counter clears on entry to UP.
- Undefined: Repeat_Pulse is tied to 0 and the repeat counter logic is absent.

Decomposition:
- Shared package key_pkg holds:
  - the FSM state typedef (UP=2'd0, PRESS_FILT=2'd1, DOWN=2'd2, REL_FILT=2'd3);
  - the default cycle constants, derived from CLK_HZ=50_000_000;
  - a function that derives a counter width from a cycle count.
- One sub-module, key_channel: synchroniser, FSM, counters and toggle register for a single key. The top instantiates NUM_KEYS copies via generate.

Test Plan (bench parameters: DEBOUNCE_CYCLES=8, LONG_CYCLES=40, REPEAT_CYCLES=10, ACTIVE_LOW=1, NUM_KEYS=4):
- Clean press: drive Key_In[0] to 0 and hold → Press_Pulse[0] for exactly 1 cycle, 11 edges after the first sampling edge; Key_State[0]=1; Toggle_Out[0]=1. Release → Release_Pulse[0] after 11 edges; Toggle_Out[0] stays 1.
- Bounce: toggle Key_In[1] every 3 cycles for 30 cycles, then return high → no pulses; Key_State[1]=0; Toggle_Out[1]=0.
- Long press: hold Key_In[2] low for 60 cycles after Press_Pulse → exactly one Long_Pulse[2], 40 cycles after Press_Pulse. With KEY_AUTO_REPEAT_EN, Repeat_Pulse[2] also fires at +50 and so on.
- Clear priority: assert Toggle_Clr[0] in the same cycle that Press_Pulse[0] registers while Toggle_Out[0]=1 → Toggle_Out[0]=0.
- Multi-channel: press keys 0 and 3 on the same edge → both Press_Pulse bits high in the same cycle; Toggle_Out=4'b1001 from reset.
- Reset mid-press: assert Rst while in DOWN → all outputs 0 immediately. With the key still held after Rst release, Press_Pulse comes after a full 11-edge debounce.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the multi-key debounce/toggle block.
//   - key_fsm_e       : per-channel debounce FSM state encoding
//   - DEF_*_CYCLES    : default cycle counts derived from a 50 MHz clock
//   - cnt_width()     : counter width needed to hold a cycle count
package key_pkg;

  typedef enum logic [1:0] {
    UP         = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } key_fsm_e;

  localparam int CLK_HZ              = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;  // 20 ms
  localparam int DEF_LONG_CYCLES     = CLK_HZ;       // 1 s
  localparam int DEF_REPEAT_CYCLES   = CLK_HZ / 5;   // 200 ms

  // Width of a counter that must represent values 0 .. cycles-1.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel: one key input path.
//   2-FF synchroniser -> polarity normalisation -> debounce FSM
//   (UP / PRESS_FILT / DOWN / REL_FILT) -> registered pulses and toggle.
// Optional feature macro: KEY_AUTO_REPEAT_EN (auto-repeat after long press).
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   key_raw        : raw asynchronous key level
//   toggle_clr     : synchronous clear of toggle_out (wins over a press)
//   key_state      : debounced level, 1 = pressed
//   press_pulse    : 1-cycle pulse on accepted press
//   release_pulse  : 1-cycle pulse on accepted release
//   long_pulse     : 1-cycle pulse once per press after LONG_CYCLES held
//   repeat_pulse   : auto-repeat pulses (0 when feature compiled out)
//   toggle_out     : flips on each accepted press
module key_channel
  import key_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  input  logic toggle_clr,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic toggle_out
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  // Hold counter saturates at LONG_CYCLES, so it needs one extra value.
  localparam int HW = cnt_width(LONG_CYCLES + 1);

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  // Synchroniser resets to the released level so a key held through reset
  // still has to pass a full debounce.
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1)
  begin : g_param_err
    $error("key_channel: invalid cycle parameters");
  end

  // ---- stage p0/p1: metastability synchroniser ----
  logic sync_p0;
  logic sync_p1;
  logic k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= IDLE_LVL;
      sync_p1 <= IDLE_LVL;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign k = (ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;

  // ---- debounce FSM: next-state and event decode ----
  key_fsm_e      state;
  key_fsm_e      state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [HW-1:0] hold;
  logic [HW-1:0] hold_nxt;
  logic          press_evt;
  logic          release_evt;
  logic          long_evt;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hold_nxt    = hold;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    long_evt    = 1'b0;
    case (state)
      UP: begin
        if (k) begin
          state_nxt = PRESS_FILT;
          cnt_nxt   = '0;
        end
      end
      PRESS_FILT: begin
        if (!k) begin
          state_nxt = UP;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = DOWN;
          press_evt = 1'b1;
          hold_nxt  = '0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DOWN: begin
        // hold passes through HOLD_LAST exactly once per press since it
        // only increments (frozen in REL_FILT) and saturates above it.
        if (hold != HOLD_MAX) hold_nxt = hold + 1'b1;
        if (hold == HOLD_LAST) long_evt = 1'b1;
        if (!k) begin
          state_nxt = REL_FILT;
          cnt_nxt   = '0;
        end
      end
      REL_FILT: begin
        // A bounce back to pressed keeps hold, so long-press timing continues.
        if (k) begin
          state_nxt = DOWN;
        end else if (cnt == DEB_LAST) begin
          state_nxt   = UP;
          release_evt = 1'b1;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = UP;
    endcase
  end

  // ---- stage p2: registered state and outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= UP;
      cnt           <= '0;
      hold          <= '0;
      key_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      toggle_out    <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      hold          <= hold_nxt;
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
      long_pulse    <= long_evt;
      if (press_evt)        key_state <= 1'b1;
      else if (release_evt) key_state <= 1'b0;
      // Clear has priority over a coincident press.
      if (toggle_clr)      toggle_out <= 1'b0;
      else if (press_evt)  toggle_out <= ~toggle_out;
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam int RW = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic          rep_armed;
  logic [RW-1:0] rep_cnt;
  logic          held;
  logic          rep_evt;

  assign held    = (state == DOWN) || (state == REL_FILT);
  assign rep_evt = rep_armed && held && (rep_cnt == REP_LAST);

  // Counting starts on the edge that registers long_pulse, so the first
  // repeat lands REPEAT_CYCLES after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_armed    <= 1'b0;
      rep_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= rep_evt;
      if (state_nxt == UP) begin
        rep_armed <= 1'b0;
        rep_cnt   <= '0;
      end else if (long_evt) begin
        rep_armed <= 1'b1;
        rep_cnt   <= '0;
      end else if (rep_armed && held) begin
        rep_cnt <= rep_evt ? '0 : rep_cnt + 1'b1;
      end
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_multi_toggle.sv
// key_multi_toggle: NUM_KEYS independent debounce/toggle channels for the
// board buttons feeding the HR/SpO2 control logic.
// Optional feature macro: KEY_AUTO_REPEAT_EN (Repeat_Pulse auto-repeat after
// a long press; Repeat_Pulse is constant 0 when undefined).
// Ports (all vectors NUM_KEYS wide, one bit per channel):
//   Clk            : system clock (50 MHz)
//   Rst            : asynchronous reset, active-high
//   Key_In         : raw asynchronous key inputs
//   Toggle_Clr     : synchronous per-channel clear of Toggle_Out
//   Key_State      : debounced level, 1 = pressed
//   Press_Pulse    : 1-cycle pulse on accepted press
//   Release_Pulse  : 1-cycle pulse on accepted release
//   Long_Pulse     : 1-cycle pulse once per press after LONG_CYCLES held
//   Repeat_Pulse   : auto-repeat pulses
//   Toggle_Out     : toggles on each accepted press
module key_multi_toggle
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [NUM_KEYS-1:0] Key_In,
  input  logic [NUM_KEYS-1:0] Toggle_Clr,
  output logic [NUM_KEYS-1:0] Key_State,
  output logic [NUM_KEYS-1:0] Press_Pulse,
  output logic [NUM_KEYS-1:0] Release_Pulse,
  output logic [NUM_KEYS-1:0] Long_Pulse,
  output logic [NUM_KEYS-1:0] Repeat_Pulse,
  output logic [NUM_KEYS-1:0] Toggle_Out
);

  if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : g_num_keys_err
    $error("key_multi_toggle: NUM_KEYS must be 1..16");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk           (Clk),
      .rst           (Rst),
      .key_raw       (Key_In[i]),
      .toggle_clr    (Toggle_Clr[i]),
      .key_state     (Key_State[i]),
      .press_pulse   (Press_Pulse[i]),
      .release_pulse (Release_Pulse[i]),
      .long_pulse    (Long_Pulse[i]),
      .repeat_pulse  (Repeat_Pulse[i]),
      .toggle_out    (Toggle_Out[i])
    );
  end

endmodule

// File: tb/tb_key_multi_toggle.sv
// tb_key_multi_toggle: directed self-checking bench for key_multi_toggle with
// DEBOUNCE_CYCLES=8, LONG_CYCLES=40, REPEAT_CYCLES=10, ACTIVE_LOW=1, 4 keys.
// Inputs change 1 time unit after a rising edge; outputs are read at the
// same point, so "tick(n)" lands just after the n-th following edge.
module tb_key_multi_toggle;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [3:0] Key_In;
  logic [3:0] Toggle_Clr;
  logic [3:0] Key_State;
  logic [3:0] Press_Pulse;
  logic [3:0] Release_Pulse;
  logic [3:0] Long_Pulse;
  logic [3:0] Repeat_Pulse;
  logic [3:0] Toggle_Out;

  key_multi_toggle #(
    .NUM_KEYS        (4),
    .ACTIVE_LOW      (1),
    .DEBOUNCE_CYCLES (8),
    .LONG_CYCLES     (40),
    .REPEAT_CYCLES   (10)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Key_In        (Key_In),
    .Toggle_Clr    (Toggle_Clr),
    .Key_State     (Key_State),
    .Press_Pulse   (Press_Pulse),
    .Release_Pulse (Release_Pulse),
    .Long_Pulse    (Long_Pulse),
    .Repeat_Pulse  (Repeat_Pulse),
    .Toggle_Out    (Toggle_Out)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  logic [3:0] seen;
  int nlong, long_at, nrep, rep_at;

  initial begin
    Rst        = 1'b1;
    Key_In     = 4'hF;
    Toggle_Clr = 4'h0;
    tick(3);
    chk("rst_key_state", Key_State, 4'h0);
    chk("rst_press", Press_Pulse, 4'h0);
    chk("rst_release", Release_Pulse, 4'h0);
    chk("rst_long", Long_Pulse, 4'h0);
    chk("rst_repeat", Repeat_Pulse, 4'h0);
    chk("rst_toggle", Toggle_Out, 4'h0);
    Rst = 1'b0;
    tick(2);

    // Clean press and release on key 0: pulse on the 11th edge.
    Key_In[0] = 1'b0;
    tick(10);
    chk("press0_early", Press_Pulse, 4'h0);
    chk("state0_early", Key_State, 4'h0);
    tick(1);
    chk("press0", Press_Pulse, 4'b0001);
    chk("state0_down", Key_State, 4'b0001);
    chk("toggle0_set", Toggle_Out, 4'b0001);
    tick(1);
    chk("press0_width", Press_Pulse, 4'h0);
    Key_In[0] = 1'b1;
    tick(10);
    chk("rel0_early", Release_Pulse, 4'h0);
    chk("state0_held", Key_State, 4'b0001);
    tick(1);
    chk("rel0", Release_Pulse, 4'b0001);
    chk("state0_up", Key_State, 4'h0);
    chk("toggle0_kept", Toggle_Out, 4'b0001);
    tick(1);
    chk("rel0_width", Release_Pulse, 4'h0);

    // Bounce on key 1: never stable for 8 cycles.
    seen = 4'h0;
    for (int i = 0; i < 30; i++) begin
      Key_In[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
      seen |= (Press_Pulse | Release_Pulse) & 4'b0010;
    end
    Key_In[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen |= (Press_Pulse | Release_Pulse) & 4'b0010;
    end
    chk("bounce_pulses", seen, 4'h0);
    chk("bounce_state", Key_State[1], 1'b0);
    chk("bounce_toggle", Toggle_Out[1], 1'b0);

    // Long press on key 2.
    Key_In[2] = 1'b0;
    tick(11);
    chk("press2", Press_Pulse, 4'b0100);
    nlong = 0; long_at = 0; nrep = 0; rep_at = 0;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (Long_Pulse[2]) begin
        nlong++;
        if (nlong == 1) long_at = i;
      end
      if (Repeat_Pulse[2]) begin
        nrep++;
        if (nrep == 1) rep_at = i;
      end
    end
    chk("long_count", nlong, 1);
    chk("long_at", long_at, 40);
`ifdef KEY_AUTO_REPEAT_EN
    chk("repeat_count", nrep, 2);
    chk("repeat_first", rep_at, 50);
`else
    chk("repeat_count", nrep, 0);
`endif
    Key_In[2] = 1'b1;
    tick(14);
    chk("state2_up", Key_State, 4'h0);
    chk("toggle_after_long", Toggle_Out, 4'b0101);

    // Clear coinciding with a press on key 0 (Toggle_Out[0] is 1): clear wins.
    Key_In[0] = 1'b0;
    tick(10);
    Toggle_Clr = 4'b0001;
    tick(1);
    chk("clr_press0", Press_Pulse, 4'b0001);
    chk("clr_priority", Toggle_Out, 4'b0100);
    Toggle_Clr = 4'h0;
    Key_In[0]  = 1'b1;
    tick(14);
    Toggle_Clr = 4'b0100;
    tick(1);
    chk("clr_plain", Toggle_Out, 4'h0);
    Toggle_Clr = 4'h0;

    // Multi-channel press from a fresh reset.
    Rst = 1'b1;
    tick(2);
    Rst = 1'b0;
    tick(2);
    Key_In = 4'b0110;
    tick(10);
    chk("multi_early", Press_Pulse, 4'h0);
    tick(1);
    chk("multi_press", Press_Pulse, 4'b1001);
    chk("multi_toggle", Toggle_Out, 4'b1001);
    chk("multi_state", Key_State, 4'b1001);

    // Reset while in DOWN, keys still held afterwards.
    tick(3);
    #2;
    Rst = 1'b1;
    #1;
    chk("midrst_state", Key_State, 4'h0);
    chk("midrst_toggle", Toggle_Out, 4'h0);
    chk("midrst_pulses", Press_Pulse | Release_Pulse | Long_Pulse | Repeat_Pulse, 4'h0);
    tick(2);
    Rst = 1'b0;
    tick(10);
    chk("postrst_early", Press_Pulse, 4'h0);
    chk("postrst_state", Key_State, 4'h0);
    tick(1);
    chk("postrst_press", Press_Pulse, 4'b1001);
    chk("postrst_toggle", Toggle_Out, 4'b1001);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
